// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_test_sequencer
// Purpose  : Stimulus/check stage for a single primitive gate (and, or, not,
//            xor, nand, nor). Walks the gate's truth table, waits a
//            programmable settle time per vector, samples the gate output and
//            compares it with the expected value. Reports pass/fail, a
//            saturating mismatch count and the first failing vector.
// Ports    : clk       - rising-edge clock
//            rst_n     - synchronous active-low reset
//            start     - run request, honoured only while idle
//            op_sel    - gate under test (0 and,1 or,2 not,3 xor,4 nand,
//                        5 nor, 6-7 illegal)
//            dut_a/b   - registered inputs driven to the gate under test
//            dut_y     - output of the gate under test
//            busy      - run in progress (includes the done cycle)
//            done      - one-cycle completion pulse
//            pass      - last run legal and mismatch-free
//            err_count - mismatches in the last run, saturating
//            fail_vec  - {a,b} of the first mismatching vector
// Revision : 1.0 - initial release
// ============================================================================
module gate_test_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_sel,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;

  // Counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly
  // SETTLE_CYCLES cycles (leaving on the cycle the counter reads zero).
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic [2:0]       op_q;
  logic [1:0]       idx_q;
  logic [3:0]       cnt_q;
  logic             dut_a_q, dut_b_q;
  logic             busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_count_q;
  logic [1:0]       fail_vec_q;

  logic             exp_y_d;
  logic             mismatch_d;
  logic [ERR_W-1:0] err_inc_d;
  logic             last_vec_d;
  logic [1:0]       idx_d;

  always_comb begin
    exp_y_d = 1'b0;
    case (op_q)
      OP_AND:  exp_y_d = dut_a_q & dut_b_q;
      OP_OR:   exp_y_d = dut_a_q | dut_b_q;
      OP_NOT:  exp_y_d = ~dut_a_q;
      OP_XOR:  exp_y_d = dut_a_q ^ dut_b_q;
      OP_NAND: exp_y_d = ~(dut_a_q & dut_b_q);
      OP_NOR:  exp_y_d = ~(dut_a_q | dut_b_q);
      default: exp_y_d = 1'b0;
    endcase
    mismatch_d = (dut_y != exp_y_d);
    err_inc_d  = (err_count_q == {ERR_W{1'b1}}) ? err_count_q
                                                : err_count_q + ERR_W'(1);
    // not walks only a = 0,1; two-input ops walk all four {a,b} codes
    last_vec_d = (op_q == OP_NOT) ? (idx_q == 2'd1) : (idx_q == 2'd3);
    idx_d      = idx_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      dut_a_q     <= 1'b0;
      dut_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      fail_vec_q  <= 2'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q        <= op_sel;
            err_count_q <= '0;
            fail_vec_q  <= 2'd0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            if (op_sel <= OP_NOR) begin
              idx_q   <= 2'd0;
              dut_a_q <= 1'b0;
              dut_b_q <= 1'b0;
              state_q <= S_DRIVE;
            end else begin
              // Illegal op: report immediately as a failed, empty run
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DRIVE: begin
          if (SETTLE_CYCLES > 0) begin
            cnt_q   <= SETTLE_LOAD;
            state_q <= S_SETTLE;
          end else begin
            state_q <= S_CHECK;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) state_q <= S_CHECK;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_CHECK: begin
          if (mismatch_d) begin
            err_count_q <= err_inc_d;
            if (err_count_q == '0) fail_vec_q <= {dut_a_q, dut_b_q};
          end
          if (last_vec_d) begin
            // pass reflects the count including this final comparison
            done_q  <= 1'b1;
            pass_q  <= (err_count_q == '0) && !mismatch_d;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_d;
            dut_a_q <= (op_q == OP_NOT) ? idx_d[0] : idx_d[1];
            dut_b_q <= (op_q == OP_NOT) ? 1'b0     : idx_d[0];
            state_q <= S_DRIVE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
`default_nettype wire
